mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the CPU's single-ported unified instruction/data memory between the instruction-fetch stage and the memory-access stage of the pipelined RISC-V core. It grants at most one access per cycle. Data accesses have priority, bounded by a starvation limit for fetch. The block drives the memory's byte enables and word address, and returns lane-aligned, sign- or zero-extended read data to the winning requester one cycle later. Its `stall_if` output feeds the hazard unit to freeze PC and IF/ID.

## Interface
- `ADDR_W`, default 8: word-address width of the memory (256 words).
- `STARVE_LIMIT`, default 4: maximum consecutive contended cycles fetch may lose; 0 = strict data priority.
- `clk` in 1: the single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `if_req` in 1: fetch read request.
- `if_addr` in 32: byte address; bits [1:0] ignored.
- `if_gnt` out 1: fetch accepted this cycle.
- `if_rvalid` out 1: fetch data valid.
- `if_rdata` out 32: instruction word.
- `d_req` in 1: data request.
- `d_we` in 1: 1 = store, 0 = load.
- `d_size` in 2: 00 byte, 01 half, 10 word (funct3[1:0]).
- `d_unsigned` in 1: zero-extend loads (funct3[2]).
- `d_addr` in 32: byte address.
- `d_wdata` in 32: store data, right-justified.
- `d_gnt` out 1: data request accepted this cycle.
- `d_rvalid` out 1: load data valid.
- `d_rdata` out 32: extended load data.
- `d_err` out 1: misaligned access flag.
- `stall_if` out 1: `if_req & ~if_gnt`.
- `mem_en` out 1: memory access this cycle.
- `mem_we` out 4: byte write enables.
- `mem_addr` out ADDR_W: word address, `addr[ADDR_W+1:2]`.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32: synchronous read data, valid the cycle after `mem_en` with `mem_we`=0.

## Operation
- Grants are combinational from the current requests.
  - Only one request present: that request wins.
  - Both present: data wins, unless `starve_cnt == STARVE_LIMIT` and `STARVE_LIMIT != 0`, in which case fetch wins.
- `starve_cnt` (clog2(STARVE_LIMIT+1) bits):
  - increments when fetch loses to data;
  - clears when fetch is granted or `if_req` is low;
  - saturates at STARVE_LIMIT.
- Store byte enables, by size:
  - byte: `mem_we = 1 << addr[1:0]`, wdata `{4{b}}`;
  - half: `mem_we = 0011 << {addr[1],1'b0}`, wdata `{2{h}}`;
  - word: `mem_we = 1111`.
- A store produces no rvalid.
- Response register holds owner (NONE/IF/D), size, `addr[1:0]` and unsigned flag. Next cycle:
  - the owner's rvalid pulses;
  - load lane extract: `mem_rdata >> (8*offset)`, then sign- or zero-extend to 32.
- A new grant in the same cycle as an rvalid is legal, giving full throughput.
- rdata outputs hold their value until the next rvalid for that port.

## Timing
- Grant to rvalid: exactly 1 cycle. Issue rate: 1 access per cycle.
- During `rst` and on the first cycle after it:
  - `if_gnt`, `d_gnt`, `mem_en`, `mem_we`, `if_rvalid`, `d_rvalid`, `d_err` = 0;
  - `if_rdata`, `d_rdata` = 0; `starve_cnt` = 0; owner = NONE; `stall_if` = 0.
- Reset asserted while a read is pending: the read is discarded and no rvalid follows.
- A requester holds its req and inputs stable until it sees gnt.
- `stall_if` is combinational.

## Configuration
- `MEM_ARB_ALIGN_CHK_EN` defined — misaligned access (half with `addr[0]`=1, word with `addr[1:0]` != 0):
  - `d_gnt` asserts, but `mem_en` stays 0 and no write occurs;
  - next cycle `d_err`=1; for loads also `d_rvalid`=1 with `d_rdata`=0.
  - A misaligned data request still counts as winning arbitration.
- `MEM_ARB_ALIGN_CHK_EN` undefined:
  - `d_err` is tied 0;
  - word accesses ignore `addr[1:0]`; half accesses ignore `addr[0]`.

## Structure
- Package `mem_arb_pkg`:
  - size encodings `SZ_B`, `SZ_H`, `SZ_W`;
  - owner enum `OWN_NONE`, `OWN_IF`, `OWN_D`;
  - byte-enable constant `BE_W`.
- Sub-module `mem_lane_align` (combinational): store byte-enable and replication, plus load extract and extend. Instantiated once, shared by the store and load paths.

## Test plan
- Both requests each cycle, STARVE_LIMIT=4: data granted 4 cycles, fetch on the 5th, pattern repeats; `stall_if`=1 for those 4 cycles.
- Store byte 0xA5 to `d_addr` 0x0000_0006: `mem_we`=0100, `mem_addr`=1, `mem_wdata`=0xA5A5A5A5.
- Memory word 0x8000_F0FF at addr 0x10:
  - LB at 0x10 gives 0xFFFF_FFFF;
  - LBU at 0x10 gives 0x0000_00FF;
  - LH at 0x12 gives 0xFFFF_8000;
  - each arrives one cycle after `d_gnt`.
- Back-to-back fetches at 0x0, 0x4, 0x8: `if_rvalid` high 3 consecutive cycles, data in order.
- `rst` asserted the cycle after a load grant: no `d_rvalid`; all outputs 0 on the following cycle.
- Macro defined, LW at 0x0000_0002: `d_gnt`=1, `mem_en`=0; next cycle `d_err`=1, `d_rvalid`=1, `d_rdata`=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: access-size encodings, response owner tags and the response
// register layout shared by the unified memory port arbiter and its lane aligner.
package mem_arb_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [3:0] BE_W = 4'b1111;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // Everything the read-return cycle needs to steer and extend mem_rdata.
    typedef struct packed {
        owner_e     owner;
        logic [1:0] size;
        logic [1:0] off;
        logic       uns;
        logic       err;
    } rsp_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        if (size == SZ_B) return 1'b0;
        if (size == SZ_H) return off[0];
        return off != 2'b00;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering. Request side builds byte
// enables and replicated store data; response side extracts and extends loads.
module mem_lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_off,
    input  logic [31:0] req_wdata,
    output logic [1:0]  req_off_eff,
    output logic [3:0]  req_be,
    output logic [31:0] req_wdata_rep,
    input  logic [1:0]  rsp_size,
    input  logic [1:0]  rsp_off,
    input  logic        rsp_unsigned,
    input  logic [31:0] rsp_raw,
    output logic [31:0] rsp_data
);

    logic [31:0] shifted;

    // NOTE: every output gets a default before the case, so no latch is inferred.
    always_comb begin
        req_off_eff   = 2'b00;
        req_be        = BE_W;
        req_wdata_rep = req_wdata;
        case (req_size)
            SZ_B: begin
                req_off_eff   = req_off;
                req_be        = 4'b0001 << req_off;
                req_wdata_rep = {4{req_wdata[7:0]}};
            end
            SZ_H: begin
                req_off_eff   = {req_off[1], 1'b0};
                req_be        = 4'b0011 << {req_off[1], 1'b0};
                req_wdata_rep = {2{req_wdata[15:0]}};
            end
            default: begin
                req_off_eff   = 2'b00;
                req_be        = BE_W;
                req_wdata_rep = req_wdata;
            end
        endcase
    end

    always_comb begin
        shifted  = rsp_raw >> {rsp_off, 3'b000};
        rsp_data = rsp_raw;
        case (rsp_size)
            SZ_B: rsp_data = rsp_unsigned ? {24'h0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H: rsp_data = rsp_unsigned ? {16'h0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: rsp_data = rsp_raw;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-access-per-cycle sharing of the unified memory between
// fetch and data. Define MEM_ARB_ALIGN_CHK_EN to trap misaligned data accesses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              stall_if,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    rsp_t          rsp;
    rsp_t          rsp_d;
    logic [SW-1:0] starve_cnt;
    logic          starve_hit;
    logic          d_mis;
    logic          d_access;
    logic [1:0]    req_off_eff;
    logic [3:0]    req_be;
    logic [31:0]   req_wdata_rep;
    logic [31:0]   rsp_word;
    logic [31:0]   d_load_data;
    logic [31:0]   if_rdata_q;
    logic [31:0]   d_rdata_q;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0], d_addr[31:ADDR_W+2]};

    // Fetch takes the port only once it has lost STARVE_LIMIT contended cycles in a row.
    assign starve_hit = (STARVE_LIMIT != 0) && (starve_cnt == LIMIT);

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!rst) begin
            if (d_req && !(if_req && starve_hit)) d_gnt = 1'b1;
            else if (if_req)                      if_gnt = 1'b1;
        end
    end

`ifdef MEM_ARB_ALIGN_CHK_EN
    assign d_mis = is_misaligned(d_size, d_addr[1:0]);
`else
    assign d_mis = 1'b0;
`endif

    // A trapped data access still wins arbitration but never reaches the memory.
    assign d_access  = d_gnt & ~d_mis;
    assign mem_en    = if_gnt | d_access;
    assign mem_we    = (d_access && d_we) ? req_be : 4'b0000;
    assign mem_addr  = if_gnt ? if_addr[ADDR_W+1:2] : d_addr[ADDR_W+1:2];
    assign mem_wdata = req_wdata_rep;
    assign stall_if  = if_req & ~if_gnt & ~rst;

    mem_lane_align u_align (
        .req_size      (d_size),
        .req_off       (d_addr[1:0]),
        .req_wdata     (d_wdata),
        .req_off_eff   (req_off_eff),
        .req_be        (req_be),
        .req_wdata_rep (req_wdata_rep),
        .rsp_size      (rsp.size),
        .rsp_off       (rsp.off),
        .rsp_unsigned  (rsp.uns),
        .rsp_raw       (mem_rdata),
        .rsp_data      (rsp_word)
    );

    always_comb begin
        rsp_d       = '0;
        rsp_d.owner = OWN_NONE;
        rsp_d.size  = d_size;
        rsp_d.off   = req_off_eff;
        rsp_d.uns   = d_unsigned;
        if (if_gnt) begin
            rsp_d.owner = OWN_IF;
        end else if (d_gnt) begin
            rsp_d.owner = d_we ? OWN_NONE : OWN_D;
            rsp_d.err   = d_mis;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            rsp        <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (!if_req || if_gnt)
                starve_cnt <= '0;
            else if (d_gnt && starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + SW'(1);
            rsp <= rsp_d;
            if (if_rvalid) if_rdata_q <= mem_rdata;
            if (d_rvalid)  d_rdata_q  <= d_load_data;
        end
    end

    // Reset masks a pending response in the same cycle it is asserted.
    assign if_rvalid   = (rsp.owner == OWN_IF) && !rst;
    assign d_rvalid    = (rsp.owner == OWN_D) && !rst;
    assign d_load_data = rsp.err ? 32'h0 : rsp_word;
    assign if_rdata    = rst ? 32'h0 : (if_rvalid ? mem_rdata : if_rdata_q);
    assign d_rdata     = rst ? 32'h0 : (d_rvalid ? d_load_data : d_rdata_q);

`ifdef MEM_ARB_ALIGN_CHK_EN
    assign d_err = rsp.err & ~rst;
`else
    assign d_err = 1'b0;
`endif

endmodule
